// File: rtl/uart_pkg.sv
// Shared types and helpers for the score-line UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit to every frame.
package uart_pkg;

    localparam int MSG_LEN = 7;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_e;

    function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
        return (d < 4'd10) ? (ASCII_ZERO + {4'h0, d}) : ASCII_QMARK;
    endfunction

    // Line layout: tens/ones of player 1, dash, player 2, CR LF
    function automatic logic [7:0] msg_byte(
        input logic [2:0] idx,
        input logic [3:0] d0,
        input logic [3:0] d1,
        input logic [3:0] d2,
        input logic [3:0] d3
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = bcd2ascii(d1);
            3'd1:    b = bcd2ascii(d0);
            3'd2:    b = ASCII_DASH;
            3'd3:    b = bcd2ascii(d3);
            3'd4:    b = bcd2ascii(d2);
            3'd5:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_score_tx_if.sv
// Byte handshake between the line sequencer and the serializer.
// start/data are taken in the cycle done pulses, giving back-to-back frames.
interface uart_score_tx_if;
    logic       start;
    logic [7:0] data;
    logic       done;

    modport master (output start, output data, input done);
    modport slave  (input start, input data, output done);
endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer with its own baud counter.
// UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_score_tx_if.slave   bif,
    output logic             o_tx
);

    localparam int CW = $clog2(DIV + 1);

    tx_state_e     r_state;
    tx_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          w_tick;
    logic          w_load;

    assign w_tick   = (r_cnt == CW'(DIV - 1));
    assign bif.done = (r_state == S_STOP) && w_tick;
    assign w_load   = bif.start && ((r_state == S_IDLE) || bif.done);
    assign o_tx     = r_tx;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        unique case (r_state)
            S_IDLE:  if (bif.start) w_state_nxt = S_START;
            S_START: if (w_tick) begin
                w_state_nxt = S_DATA;
                w_bit_nxt   = 3'd0;
            end
            S_DATA:  if (w_tick) begin
                w_bit_nxt = r_bit + 3'd1;
                if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`endif
            S_STOP:  if (w_tick) begin
                w_state_nxt = bif.start ? S_START : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line level for the next cycle keeps o_tx registered
        unique case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = ^r_shift;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            if (w_load) r_shift <= bif.data;
            if ((r_state == S_IDLE) || w_tick) r_cnt <= '0;
            else                               r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_score_tx.sv
// Sends the score line "tens ones - tens ones CR LF" on each send request.
// UART_TX_PARITY_EN switches the framing from 8N1 to 8E1.
module uart_score_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    output logic       busy,
    output logic       RsTx
);

    localparam int DIV = CLK_HZ / BAUD;

    uart_score_tx_if bif ();

    logic       r_active;
    logic       r_pending;
    logic [2:0] r_idx;
    logic [3:0] r_snap0;
    logic [3:0] r_snap1;
    logic [3:0] r_snap2;
    logic [3:0] r_snap3;
    logic       w_req;
    logic       w_last;
    logic       w_line;
    logic       w_next;

    assign w_req  = send || r_pending;
    assign w_last = bif.done && (r_idx == 3'(MSG_LEN - 1));
    assign w_line = w_req && (!r_active || w_last);
    assign w_next = bif.done && !w_last;

    // First byte of a new line comes from the live digits being snapshotted
    assign bif.start = w_line || w_next;
    assign bif.data  = w_line ? bcd2ascii(dig1)
                     : msg_byte(r_idx + 3'd1, r_snap0, r_snap1,
                                r_snap2, r_snap3);
    assign busy = r_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active  <= 1'b0;
            r_pending <= 1'b0;
            r_idx     <= 3'd0;
            r_snap0   <= 4'h0;
            r_snap1   <= 4'h0;
            r_snap2   <= 4'h0;
            r_snap3   <= 4'h0;
        end else if (w_line) begin
            r_active  <= 1'b1;
            r_pending <= 1'b0;
            r_idx     <= 3'd0;
            r_snap0   <= dig0;
            r_snap1   <= dig1;
            r_snap2   <= dig2;
            r_snap3   <= dig3;
        end else begin
            if (w_last)            r_active  <= 1'b0;
            if (w_next)            r_idx     <= r_idx + 3'd1;
            if (r_active && send)  r_pending <= 1'b1;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_ser (
        .clk   (clk),
        .rst_n (reset),
        .bif   (bif),
        .o_tx  (RsTx)
    );

endmodule

// File: tb/tb_uart_score_tx.sv
// Directed bench for uart_score_tx at DIV=16 with a serial decoder.
// Build with UART_TX_PARITY_EN to check 8E1 framing.
module tb_uart_score_tx;

    localparam int CLK_HZ = 160_000;
    localparam int BAUD   = 10_000;
    localparam int DIV    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int LINE   = 7 * NBITS * DIV;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       send  = 1'b0;
    logic [3:0] dig0  = 4'h0;
    logic [3:0] dig1  = 4'h0;
    logic [3:0] dig2  = 4'h0;
    logic [3:0] dig3  = 4'h0;
    logic       busy;
    logic       RsTx;

    int checks     = 0;
    int errors     = 0;
    int busy_cyc   = 0;
    int busy_falls = 0;
    logic busy_q   = 1'b0;

    always #5 clk = ~clk;

    uart_score_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .send  (send),
        .dig0  (dig0),
        .dig1  (dig1),
        .dig2  (dig2),
        .dig3  (dig3),
        .busy  (busy),
        .RsTx  (RsTx)
    );

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (busy_q && !busy) busy_falls++;
        busy_q = busy;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_send();
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic rx_byte(input string tag, input logic [7:0] exp,
                           output int waited);
        int n = 0;
        logic [7:0] b;
        while (RsTx !== 1'b0 && n < 4 * NBITS * DIV) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (RsTx !== 1'b0) begin
            check({tag, "_timeout"}, RsTx, 0);
            return;
        end
        repeat (DIV / 2) @(negedge clk);
        check({tag, "_start"}, RsTx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = RsTx;
        end
        check(tag, b, exp);
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        check({tag, "_par"}, RsTx, ^exp);
`endif
        repeat (DIV) @(negedge clk);
        check({tag, "_stop"}, RsTx, 1);
    endtask

    task automatic rx_line(input string tag, input logic [55:0] m,
                           output int w0);
        int w;
        for (int k = 0; k < 7; k++) begin
            rx_byte($sformatf("%s_b%0d", tag, k), m[8*(6-k) +: 8], w);
            if (k == 0) w0 = w;
            else check($sformatf("%s_gap%0d", tag, k), w, DIV / 2);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3 * LINE) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w0;
        int c0;
        int f0;
        int zeros;
        int hb;

        repeat (3) @(negedge clk);
        check("rst_tx", RsTx, 1);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // line content, latency, snapshot
        dig1 = 4'd0; dig0 = 4'd7; dig3 = 4'd1; dig2 = 4'd2;
        c0 = busy_cyc;
        pulse_send();
        check("lat_busy", busy, 1);
        check("lat_tx", RsTx, 0);
        dig0 = 4'd9;
        rx_line("t1", 56'h30372D31320D0A, w0);
        wait_idle("t1_idle");
        check("t1_len", busy_cyc - c0, LINE);

        // invalid digit, then send on the final stop edge
        dig1 = 4'd9; dig0 = 4'd9; dig3 = 4'hB; dig2 = 4'd5;
        c0 = busy_cyc;
        f0 = busy_falls;
        pulse_send();
        rx_line("t2", 56'h39392D3F350D0A, w0);
        repeat (DIV / 2 - 1) @(negedge clk);
        pulse_send();
        rx_line("t2b", 56'h39392D3F350D0A, w0);
        check("t2b_gap", w0, 0);
        wait_idle("t2_idle");
        check("t2_len", busy_cyc - c0, 2 * LINE);
        check("t2_falls", busy_falls - f0, 1);

        // three requests during a line merge into one more line
        dig1 = 4'd4; dig0 = 4'd2; dig3 = 4'd0; dig2 = 4'd3;
        c0 = busy_cyc;
        f0 = busy_falls;
        pulse_send();
        fork
            begin
                rx_line("t3a", 56'h34322D30330D0A, w0);
                rx_line("t3b", 56'h34322D30330D0A, w0);
                check("t3_gap", w0, DIV / 2);
            end
            begin
                repeat (300) @(negedge clk);
                pulse_send();
                repeat (300) @(negedge clk);
                pulse_send();
                repeat (300) @(negedge clk);
                pulse_send();
            end
        join
        wait_idle("t3_idle");
        check("t3_len", busy_cyc - c0, 2 * LINE);
        check("t3_falls", busy_falls - f0, 1);
        zeros = 0;
        for (int i = 0; i < 2 * NBITS * DIV; i++) begin
            @(negedge clk);
            if (RsTx !== 1'b1) zeros++;
        end
        check("t3_no_third", zeros, 0);

        // reset in the middle of byte 2
        pulse_send();
        rx_byte("t4_b0", 8'h34, w0);
        rx_byte("t4_b1", 8'h32, w0);
        repeat (3 * DIV) @(negedge clk);
        check("t4_pre_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("t4_rst_tx", RsTx, 1);
        check("t4_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        zeros = 0;
        hb = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (RsTx !== 1'b1) zeros++;
            if (busy !== 1'b0) hb++;
        end
        check("t4_quiet_tx", zeros, 0);
        check("t4_quiet_busy", hb, 0);
        pulse_send();
        check("t4_restart", RsTx, 0);
        rx_line("t4r", 56'h34322D30330D0A, w0);
        wait_idle("t4_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
